// File: rtl/ring_arbiter_pkg.sv
// ring_arbiter_pkg: shared types and default constants for the ring arbiter.
//   state_e          - arbiter FSM state (IDLE: no owner, OWNED: one owner)
//   N_DEFAULT        - default number of requesters
//   MAX_HOLD_DEFAULT - default maximum tenure when preemption is compiled in
package ring_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  localparam int unsigned N_DEFAULT        = 4;
  localparam int unsigned MAX_HOLD_DEFAULT = 8;

endpackage

// File: rtl/ring_arbiter_if.sv
// ring_arbiter_if: request/grant bundle between requesters and the arbiter.
//   req    - per-requester level request (driven by master)
//   gnt    - one-hot grant or all-zero (driven by slave)
//   gnt_id - index of the current owner, 0 when no owner
//   busy   - high while a grant is outstanding
// Modports: master (requester side), slave (arbiter side).
interface ring_arbiter_if
  import ring_arbiter_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) ();

  localparam int unsigned W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [W-1:0] gnt_id;
  logic         busy;

  modport master (output req, input gnt, input gnt_id, input busy);
  modport slave  (input req, output gnt, output gnt_id, output busy);

endinterface

// File: rtl/ring_ptr.sv
// ring_ptr: one-hot round-robin priority pointer.
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset, pointer returns to bit 0
//   rotate_en - load the pointer on this edge
//   load_idx  - index the pointer becomes one-hot at when rotate_en is high
//   ptr       - one-hot highest-priority position
module ring_ptr
  import ring_arbiter_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rotate_en,
  input  logic [$clog2(N)-1:0] load_idx,
  output logic [N-1:0]         ptr
);

  logic [N-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (rotate_en) ptr_d = N'(1) << load_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= N'(1);
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/ring_arbiter.sv
// ring_arbiter: round-robin arbiter with a rotating one-hot priority pointer.
// The owner keeps the grant while its request stays high; on release the
// pointer moves past the owner and the grant passes on without an idle cycle.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - ring_arbiter_if.slave (req in; gnt, gnt_id, busy out)
// Optional macro RING_ARBITER_PREEMPT_EN adds a tenure counter that forces
// rotation after MAX_HOLD cycles when another requester is waiting.
module ring_arbiter
  import ring_arbiter_pkg::*;
#(
  parameter int unsigned N        = N_DEFAULT,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  ring_arbiter_if.slave  bus
);

  localparam int unsigned W = $clog2(N);

  state_e       state_q, state_d;
  logic [W-1:0] owner_q, owner_d;
  logic [N-1:0] ptr;
  logic [W-1:0] ptr_idx;
  logic         rotate_en;
  logic [W-1:0] load_idx;
  logic [W-1:0] nxt_idx;
  logic [N-1:0] others;
  logic         handoff;

  // First set bit of r at or above base, wrapping from N-1 to 0.
  function automatic logic [W-1:0] pick(input logic [N-1:0] r, input logic [W-1:0] base);
    logic [W-1:0] win;
    int unsigned  idx;
    win = '0;
    // Scan from the farthest offset down so the nearest hit is written last.
    for (int unsigned k = N; k > 0; k--) begin
      idx = (32'(base) + k - 1) % N;
      if (r[idx]) win = W'(idx);
    end
    return win;
  endfunction

  ring_ptr #(.N(N)) u_ptr (
    .clk       (clk),
    .rst_n     (rst_n),
    .rotate_en (rotate_en),
    .load_idx  (load_idx),
    .ptr       (ptr)
  );

  always_comb begin
    ptr_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (ptr[i]) ptr_idx = W'(i);
    end
  end

`ifdef RING_ARBITER_PREEMPT_EN
  localparam int unsigned CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] CNT_LIM = CW'(MAX_HOLD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          grant_new;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rotate_en = 1'b0;
    load_idx  = '0;
    nxt_idx   = (owner_q == W'(N - 1)) ? '0 : owner_q + 1'b1;
    others    = bus.req & ~(N'(1) << owner_q);
    handoff   = !bus.req[owner_q];
`ifdef RING_ARBITER_PREEMPT_EN
    grant_new = 1'b0;
    if (cnt_q == CNT_LIM && |others) handoff = 1'b1;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = OWNED;
          owner_d = pick(bus.req, ptr_idx);
`ifdef RING_ARBITER_PREEMPT_EN
          grant_new = 1'b1;
`endif
        end
      end
      OWNED: begin
        if (handoff) begin
          rotate_en = 1'b1;
          load_idx  = nxt_idx;
          // Winner is chosen under the rotated pointer in the same edge.
          if (|others) begin
            owner_d = pick(others, nxt_idx);
`ifdef RING_ARBITER_PREEMPT_EN
            grant_new = 1'b1;
`endif
          end else begin
            state_d = IDLE;
            owner_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = '0;
      end
    endcase
  end

`ifdef RING_ARBITER_PREEMPT_EN
  always_comb begin
    cnt_d = cnt_q;
    if (grant_new)                                  cnt_d = '0;
    else if (state_q == OWNED && cnt_q != CNT_LIM)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  assign bus.busy   = (state_q == OWNED);
  assign bus.gnt    = (state_q == OWNED) ? (N'(1) << owner_q) : '0;
  assign bus.gnt_id = (state_q == OWNED) ? owner_q : '0;

endmodule

// File: doc/ring_arbiter.md
RING_ARBITER -- requirements
Module: ring_arbiter

Interface
REQ-001 Parameter: N, default 4, number of requesters (N >= 2).
REQ-002 Parameter: MAX_HOLD, default 8, maximum grant tenure in cycles when preemption is compiled in (MAX_HOLD >= 1).
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: req  input  N  per-requester request, level-sensitive, sampled every rising edge.
REQ-006 Port: gnt  output  N  registered one-hot grant, or all-zero when no owner.
REQ-007 Port: gnt_id  output  clog2(N)  index of the current owner; 0 when gnt is all-zero.
REQ-008 Port: busy  output  1  high exactly when gnt is nonzero.

Function
REQ-009 The block SHALL hold a one-hot priority pointer ptr[N-1:0] that rotates like a ring; ptr marks the highest-priority requester.
REQ-010 FSM states SHALL be IDLE (no owner) and OWNED (one owner); busy = (state == OWNED).
REQ-011 Arbitration SHALL select the first asserted req bit at or above the ptr position, searching upward with wrap from index N-1 to 0.
REQ-012 IDLE with any req bit high at an edge -> OWNED; gnt and gnt_id for the winner are valid after that same edge, giving 1-cycle latency.
REQ-013 IDLE with req all-zero SHALL stay IDLE; ptr is unchanged.
REQ-014 OWNED with req[owner] high SHALL hold gnt unchanged; requests from other requesters SHALL NOT disturb the grant.
REQ-015 OWNED with req[owner] low at an edge: ptr SHALL become one-hot at (owner+1) mod N.
REQ-016 At that same edge, if another req bit is high, the grant SHALL pass directly to the winner under the new ptr, with no idle cycle; otherwise the FSM SHALL return to IDLE and gnt SHALL become 0.
REQ-017 ptr SHALL rotate only on release or preemption, never in IDLE.
REQ-018 Owner index wrap: release by requester N-1 SHALL set ptr to bit 0.
REQ-019 gnt SHALL never have more than one bit set, in any cycle.

Reset
REQ-020 While rst_n is low, outputs SHALL read gnt=0, gnt_id=0 and busy=0, and internal state SHALL be state=IDLE and ptr=one-hot bit 0, independent of clk.
REQ-021 Reset asserted mid-tenure SHALL drop gnt immediately (asynchronously); the previous owner gets no priority after reset.
REQ-022 On the first edge after rst_n rises, arbitration SHALL proceed normally from ptr=bit 0.

Configuration
REQ-023 Macro RING_ARBITER_PREEMPT_EN SHALL gate a tenure counter and forced rotation.
REQ-024 With the macro defined:
- the counter SHALL clear on every new grant and increment each OWNED cycle;
- when it reaches MAX_HOLD-1 and any other req bit is high, the next edge SHALL preempt the owner, with ptr and grant handled as in REQ-015/REQ-016;
- with no competitor, the owner SHALL keep the grant, and the counter SHALL saturate.
REQ-025 Without the macro there SHALL be no counter logic, and the owner SHALL hold the grant until it deasserts req.

Structure
REQ-026 Shared package ring_arbiter_pkg SHALL contain the FSM state enum (IDLE, OWNED) and the default constants for N and MAX_HOLD.
REQ-027 The pointer SHALL be a sub-module ring_ptr: N-bit one-hot register, asynchronous active-low reset to bit 0, inputs rotate_en and load_idx, output ptr.
REQ-028 The top SHALL contain the FSM, the wrap-around priority select, the gnt_id encoder and the optional counter.

Verification
REQ-029 Release reset, N=4, req=4'b0110 -> one edge later gnt=4'b0010, gnt_id=1, busy=1.
REQ-030 Owner 1 drops its request so req=4'b0100 -> next edge gnt=4'b0100, ptr=bit 2, busy stays 1 with no gap.
REQ-031 Owner 3 with req=4'b1001, then owner 3 releases -> gnt=4'b0001 (wrap), ptr=bit 0.
REQ-032 rst_n pulsed low mid-tenure with req=4'b1111 -> gnt=0 without a clock edge; after release, gnt=4'b0001.
REQ-033 RING_ARBITER_PREEMPT_EN, MAX_HOLD=3, req=4'b0011 held -> gnt alternates 0001/0010 every 3 cycles; req=4'b0001 alone -> gnt=4'b0001 held indefinitely.
REQ-034 Every bench SHALL check that gnt is one-hot-or-zero and that gnt_id and busy are consistent with gnt on every cycle.
